uart_imem_loader: RTL and testbench

//   Sequences the UART RX byte stream into instruction-memory writes during boot load.

---
 rtl/uart_imem_loader.sv | 155 +++++++++++++++
 tb/tb_uart_imem_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART RX bytes (LSB first) into 32-bit words and writes them
// to consecutive imem addresses until a terminator word or a full memory.
module uart_imem_loader #(
  parameter int unsigned ADDR_W      = 5,
  parameter logic [31:0] TERM_WORD   = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              loading,
  output logic [ADDR_W:0]   word_count,
  output logic              write_done,
  output logic              mem_full,
  output logic              frame_err
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {COLLECT, COMMIT, DONE} state_t;

  state_t            state, state_d;
  logic [1:0]        byte_idx, byte_idx_d;
  logic [31:0]       word, word_d;
  logic [ADDR_W-1:0] word_ptr, word_ptr_d;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_d;
  logic              imem_we_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [31:0]       imem_wdata_d;
  logic              loading_d;
  logic [ADDR_W:0]   word_count_d;
  logic              write_done_d;
  logic              mem_full_d;
  logic              frame_err_d;
  logic [31:0]       assembled;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      byte_idx   <= '0;
      word       <= '0;
      word_ptr   <= '0;
      idle_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      loading    <= 1'b0;
      word_count <= '0;
      write_done <= 1'b0;
      mem_full   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      byte_idx   <= byte_idx_d;
      word       <= word_d;
      word_ptr   <= word_ptr_d;
      idle_cnt   <= idle_cnt_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      loading    <= loading_d;
      word_count <= word_count_d;
      write_done <= write_done_d;
      mem_full   <= mem_full_d;
      frame_err  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    byte_idx_d   = byte_idx;
    word_d       = word;
    word_ptr_d   = word_ptr;
    idle_cnt_d   = '0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    loading_d    = loading;
    word_count_d = word_count;
    write_done_d = write_done;
    mem_full_d   = mem_full;
    frame_err_d  = frame_err;
    assembled    = {uart_rx_data, word[23:0]};

    unique case (state)
      COLLECT: begin
        if (uart_rx_break) begin
          if (byte_idx != 2'd0) begin
            byte_idx_d  = '0;
            frame_err_d = 1'b1;
          end
        end else if (uart_rx_valid) begin
          loading_d = 1'b1;
          word_d[{byte_idx, 3'b000} +: 8] = uart_rx_data;
          if (byte_idx == 2'd3) begin
            state_d    = COMMIT;
            byte_idx_d = '0;
            // Write port is loaded on the 4th-byte edge so the strobe is visible during COMMIT.
            if (assembled != TERM_WORD) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_ptr;
              imem_wdata_d = assembled;
            end
          end else begin
            byte_idx_d = byte_idx + 2'd1;
          end
        end else if (byte_idx != 2'd0) begin
          if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
            byte_idx_d  = '0;
            frame_err_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt + IDLE_W'(1);
          end
        end
      end

      COMMIT: begin
        if (word == TERM_WORD) begin
          state_d      = DONE;
          write_done_d = 1'b1;
          loading_d    = 1'b0;
        end else begin
          word_ptr_d   = word_ptr + ADDR_W'(1);
          word_count_d = word_count + (ADDR_W + 1)'(1);
          if (word_ptr == '1) begin
            state_d      = DONE;
            write_done_d = 1'b1;
            mem_full_d   = 1'b1;
            loading_d    = 1'b0;
          end else begin
            state_d = COLLECT;
            if (uart_rx_valid && !uart_rx_break) begin
              word_d[7:0] = uart_rx_data;
              byte_idx_d  = 2'd1;
            end
          end
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized bench for uart_imem_loader: byte-level reference model feeds a write
// scoreboard; a negedge monitor pops and compares every imem write.
module tb_uart_imem_loader;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned TIMEOUT = 40;
  localparam logic [31:0] TERM    = 32'hFFFF_FFFF;

  logic              clk;
  logic              rst;
  logic              uart_rx_valid;
  logic [7:0]        uart_rx_data;
  logic              uart_rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              loading;
  logic [ADDR_W:0]   word_count;
  logic              write_done;
  logic              mem_full;
  logic              frame_err;

  uart_imem_loader #(
    .ADDR_W     (ADDR_W),
    .TERM_WORD  (TERM),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data (uart_rx_data),
    .uart_rx_break(uart_rx_break),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .loading      (loading),
    .word_count   (word_count),
    .write_done   (write_done),
    .mem_full     (mem_full),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+31:0] exp_q[$];

  // reference model state
  logic [7:0]  m_pend[$];
  int unsigned m_ptr;
  bit          m_done, m_full, m_ferr, m_loading;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && imem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%08h expected addr=%0h data=%08h",
                   imem_addr, imem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  function automatic void model_reset();
    m_pend.delete();
    m_ptr = 0; m_done = 0; m_full = 0; m_ferr = 0; m_loading = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (m_done) return;
    m_loading = 1;
    m_pend.push_back(b);
    if (m_pend.size() == 4) begin
      w = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
      m_pend.delete();
      if (w == TERM) begin
        m_done = 1; m_loading = 0;
      end else begin
        exp_q.push_back({m_ptr[ADDR_W-1:0], w});
        m_ptr++;
        if (m_ptr == DEPTH) begin
          m_done = 1; m_full = 1; m_loading = 0;
        end
      end
    end
  endfunction

  function automatic void model_abort();
    if (!m_done && m_pend.size() != 0) begin
      m_pend.delete();
      m_ferr = 1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_break(input bit with_valid, input logic [7:0] b);
    model_abort();
    uart_rx_break = 1'b1;
    uart_rx_valid = with_valid;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_break = 1'b0;
    uart_rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
    if (n >= TIMEOUT) model_abort();
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned max_gap);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[8*i +: 8]);
      idle($urandom_range(max_gap, 0));
    end
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag);
    idle(6);
    chk({tag, "_pending"},    64'(exp_q.size()), 64'd0);
    chk({tag, "_word_count"}, 64'(word_count),   64'(m_ptr));
    chk({tag, "_write_done"}, 64'(write_done),   64'(m_done));
    chk({tag, "_mem_full"},   64'(mem_full),     64'(m_full));
    chk({tag, "_frame_err"},  64'(frame_err),    64'(m_ferr));
    chk({tag, "_loading"},    64'(loading),      64'(m_loading));
  endtask

  initial begin
    rst = 1'b1;
    uart_rx_valid = 1'b0;
    uart_rx_data  = '0;
    uart_rx_break = 1'b0;
    model_reset();
    @(negedge clk);

    // 1: reset values
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_we",     64'(imem_we),    64'd0);
    chk("rst_addr",   64'(imem_addr),  64'd0);
    chk("rst_wdata",  64'(imem_wdata), 64'd0);
    chk("rst_flags",  64'({loading, write_done, mem_full, frame_err}), 64'd0);
    chk("rst_wcount", 64'(word_count), 64'd0);
    rst = 1'b0;
    model_reset();

    // 2: two back-to-back words, strobe one clk after 4th byte
    send_byte(8'h13); send_byte(8'h01); send_byte(8'h01); send_byte(8'hFC);
    chk("latency_we", 64'(imem_we), 64'd1);
    send_word(32'h02812E23, 0);
    check_flags("t2");

    // 3: terminator stops the load
    do_reset(2);
    send_word(32'h00100793, 1);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    @(negedge clk);
    chk("t3_done_next", 64'(write_done), 64'd1);
    send_word(32'hDDCCBBAA, 0);
    check_flags("t3");

    // 4: partial word discarded by timeout
    do_reset(2);
    send_byte(8'h11); send_byte(8'h22);
    idle(TIMEOUT + 1);
    send_word(32'h00100793, 0);
    check_flags("t4");

    // 5: memory full after DEPTH words
    do_reset(2);
    for (int i = 0; i <= DEPTH; i++) send_word(32'(i), 1);
    check_flags("t5");

    // 6: reset mid-word, then break after 3 bytes, break+valid collision
    do_reset(2);
    send_byte(8'h11); send_byte(8'h22);
    do_reset(1);
    send_word(32'h04010413, 0);
    check_flags("t6a");
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_break(1'b0, 8'h00);
    check_flags("t6b");
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    send_break(1'b1, 8'h08);
    send_word(32'h00000000, 0);
    check_flags("t6c");

    // 7: randomized traffic
    for (int r = 0; r < 3; r++) begin
      int unsigned n;
      do_reset(2);
      n = $urandom_range(45, 15);
      for (int k = 0; k < int'(n); k++) begin
        int unsigned sel;
        sel = $urandom_range(19, 0);
        if (sel == 0) begin
          send_break($urandom_range(1, 0) == 1, 8'($urandom));
        end else if (sel == 1) begin
          for (int j = 0; j < int'($urandom_range(3, 1)); j++) send_byte(8'($urandom));
          send_break($urandom_range(1, 0) == 1, 8'($urandom));
        end else if (sel == 2 && r == 2) begin
          send_word(TERM, 2);
        end else if (sel < 5) begin
          send_word(32'h0, 2);
        end else begin
          send_word($urandom, 3);
        end
      end
      check_flags("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
